// File: rtl/tdm_audio_deserializer.sv
`default_nettype none
// ============================================================================
// tdm_audio_deserializer : oversampled 16-slot TDM capture, frame-atomic publish
// Revision 1.0
// ============================================================================
module tdm_audio_deserializer #(
    parameter int IO_WIDTH     = 24,
    parameter int NUM_CHANNELS = 16,
    parameter int SLOT_BITS    = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tdm_sclk,
    input  logic                tdm_fsync,
    input  logic                tdm_sdata,
    output logic [IO_WIDTH-1:0] audio_inputs [0:NUM_CHANNELS-1],
    output logic                frame_strobe,
    output logic                frame_error,
    output logic                locked
);

    localparam int BIT_W  = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam int SLOT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST      = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_DATA_LAST = BIT_W'(IO_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(NUM_CHANNELS - 1);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q,  sclk_sync_d;
    logic [SYNC_STAGES-1:0] fsync_sync_q, fsync_sync_d;
    logic [SYNC_STAGES-1:0] sdata_sync_q, sdata_sync_d;
    logic                   sclk_prev_q,  sclk_prev_d;
    logic                   rise_q,       rise_d;
    logic                   fsync_s_q,    fsync_s_d;
    logic                   sdata_s_q,    sdata_s_d;

    state_t                 state_q,      state_d;
    logic [BIT_W-1:0]       bit_cnt_q,    bit_cnt_d;
    logic [SLOT_W-1:0]      slot_cnt_q,   slot_cnt_d;
    logic [IO_WIDTH-1:0]    shift_q,      shift_d;
    logic [IO_WIDTH-1:0]    shadow_q [0:NUM_CHANNELS-1];
    logic [IO_WIDTH-1:0]    shadow_d [0:NUM_CHANNELS-1];
    logic [IO_WIDTH-1:0]    audio_q  [0:NUM_CHANNELS-1];
    logic [IO_WIDTH-1:0]    audio_d  [0:NUM_CHANNELS-1];
    logic                   strobe_q,     strobe_d;
    logic                   error_q,      error_d;
    logic                   locked_q,     locked_d;

    logic [IO_WIDTH-1:0]    word;
    logic                   frame_end;

    always_comb begin
        // One shared chain depth keeps fsync/sdata aligned with the sclk edge
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0],  tdm_sclk};
        fsync_sync_d = {fsync_sync_q[SYNC_STAGES-2:0], tdm_fsync};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], tdm_sdata};
        sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
        rise_d       = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
        fsync_s_d    = fsync_sync_q[SYNC_STAGES-1];
        sdata_s_d    = sdata_sync_q[SYNC_STAGES-1];

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        shift_d    = shift_q;
        shadow_d   = shadow_q;
        audio_d    = audio_q;
        strobe_d   = 1'b0;
        error_d    = 1'b0;
        locked_d   = locked_q;

        word      = {shift_q[IO_WIDTH-2:0], sdata_s_q};
        frame_end = (slot_cnt_q == SLOT_LAST) && (bit_cnt_q == BIT_LAST);

        if (rise_q) begin
            case (state_q)
                HUNT: begin
                    if (fsync_s_q) begin
                        state_d    = RUN;
                        bit_cnt_d  = '0;
                        slot_cnt_d = '0;
                    end
                end
                default: begin
                    shift_d = word;
                    if (fsync_s_q && !frame_end) begin
                        error_d    = 1'b1;
                        locked_d   = 1'b0;
                        bit_cnt_d  = '0;
                        slot_cnt_d = '0;
                    end else begin
                        if (bit_cnt_q == BIT_DATA_LAST) begin
                            shadow_d[slot_cnt_q] = word;
                        end
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d  = '0;
                            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                        // shadow_d rather than shadow_q so SLOT_BITS == IO_WIDTH still publishes the last word
                        if (frame_end) begin
                            slot_cnt_d = '0;
                            audio_d    = shadow_d;
                            strobe_d   = 1'b1;
                            if (fsync_s_q) begin
                                locked_d = 1'b1;
                            end else begin
                                error_d  = 1'b1;
                                locked_d = 1'b0;
                                state_d  = HUNT;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_q  <= '0;
            fsync_sync_q <= '0;
            sdata_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            rise_q       <= 1'b0;
            fsync_s_q    <= 1'b0;
            sdata_s_q    <= 1'b0;
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            shift_q      <= '0;
            shadow_q     <= '{default: '0};
            audio_q      <= '{default: '0};
            strobe_q     <= 1'b0;
            error_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            fsync_sync_q <= fsync_sync_d;
            sdata_sync_q <= sdata_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            rise_q       <= rise_d;
            fsync_s_q    <= fsync_s_d;
            sdata_s_q    <= sdata_s_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            shadow_q     <= shadow_d;
            audio_q      <= audio_d;
            strobe_q     <= strobe_d;
            error_q      <= error_d;
            locked_q     <= locked_d;
        end
    end

    assign audio_inputs = audio_q;
    assign frame_strobe = strobe_q;
    assign frame_error  = error_q;
    assign locked       = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_audio_deserializer.sv
`default_nettype none
// ============================================================================
// tb_tdm_audio_deserializer : frame table + scoreboard bench for the TDM capture
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tdm_audio_deserializer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tdm_sclk = 1'b0;
    logic        tdm_fsync = 1'b0;
    logic        tdm_sdata = 1'b0;
    logic [23:0] audio_inputs [0:15];
    logic        frame_strobe;
    logic        frame_error;
    logic        locked;

    tdm_audio_deserializer #(
        .IO_WIDTH    (24),
        .NUM_CHANNELS(16),
        .SLOT_BITS   (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tdm_sclk    (tdm_sclk),
        .tdm_fsync   (tdm_fsync),
        .tdm_sdata   (tdm_sdata),
        .audio_inputs(audio_inputs),
        .frame_strobe(frame_strobe),
        .frame_error (frame_error),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    typedef logic [15:0][23:0] frame_t;

    typedef struct packed {
        frame_t vals;
        logic   err;
        logic   lock;
    } exp_t;

    typedef struct {
        logic [23:0] base;
        logic [23:0] step;
        logic [7:0]  pad;
        logic        end_fs;
    } vec_t;

    exp_t   sb[$];
    vec_t   tbl[4];
    int     checks = 0;
    int     errors = 0;
    int     strobe_cnt = 0;
    int     err_cnt = 0;
    int     exp_frames = 0;
    frame_t last_good = '0;
    logic [23:0] prev_audio [0:15];
    logic   prev_rst_n = 1'b0;

    function automatic frame_t build(input logic [23:0] base, input logic [23:0] step);
        frame_t f;
        for (int n = 0; n < 16; n++) f[n] = base + step * 24'(n);
        return f;
    endfunction

    task automatic check_audio(input string name, input frame_t e);
        int bad = 0;
        int first = -1;
        for (int n = 0; n < 16; n++) begin
            if (audio_inputs[n] !== e[n]) begin
                bad++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d channels differ, ch%0d got %h want %h",
                     name, bad, first, audio_inputs[first], e[first]);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Scoreboard side: every strobe pops one expected frame
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_error) err_cnt++;
            if (frame_strobe) begin
                strobe_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got strobe want none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_audio("frame_audio", e.vals);
                    check_val("frame_error_at_strobe", int'(frame_error), int'(e.err));
                    check_val("locked_at_strobe", int'(locked), int'(e.lock));
                    last_good = e.vals;
                end
            end else if (prev_rst_n) begin
                for (int n = 0; n < 16; n++) begin
                    if (audio_inputs[n] !== prev_audio[n]) begin
                        checks++;
                        errors++;
                        $display("FAIL audio_stable: ch%0d got %h want %h", n, audio_inputs[n], prev_audio[n]);
                    end
                end
            end
        end
        prev_audio = audio_inputs;
        prev_rst_n = reset_n;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic fs, input logic sd);
        @(negedge clk);
        tdm_sclk  = 1'b0;
        tdm_fsync = fs;
        tdm_sdata = sd;
        repeat (4) @(negedge clk);
        tdm_sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input frame_t v, input logic [7:0] pad, input logic end_fs, input int limit);
        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < 32; b++) begin
                if (s * 32 + b < limit) begin
                    send_bit((s == 15 && b == 31) ? end_fs : 1'b0,
                             (b < 24) ? v[s][23-b] : pad[31-b]);
                end
            end
        end
    endtask

    task automatic run_frame(input frame_t v, input logic [7:0] pad, input logic end_fs);
        sb.push_back('{vals: v, err: !end_fs, lock: end_fs});
        exp_frames++;
        send_frame(v, pad, end_fs, 512);
        idle(4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int e0;
        tbl[0] = '{base: 24'hA00000, step: 24'h000001, pad: 8'h00, end_fs: 1'b1};
        tbl[1] = '{base: 24'hA00000, step: 24'h000001, pad: 8'h00, end_fs: 1'b1};
        tbl[2] = '{base: 24'h000001, step: 24'h000000, pad: 8'hFF, end_fs: 1'b1};
        tbl[3] = '{base: 24'h123456, step: 24'h010101, pad: 8'h5A, end_fs: 1'b0};

        // Reset
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_audio("reset_audio", '0);
        check_val("reset_strobe", int'(frame_strobe), 0);
        check_val("reset_error", int'(frame_error), 0);
        check_val("reset_locked", int'(locked), 0);
        reset_n = 1'b1;
        idle(4);

        // Clean frames, padding, missing end fsync
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_frame(build(tbl[i].base, tbl[i].step), tbl[i].pad, tbl[i].end_fs);
        end
        check_val("unlocked_after_missing_fsync", int'(locked), 0);

        // Rises without fsync are ignored while hunting
        s0 = strobe_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 40; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
        idle(4);
        check_val("hunt_no_strobe", strobe_cnt, s0);
        check_val("hunt_no_error", err_cnt, e0);
        check_val("hunt_locked", int'(locked), 0);
        check_audio("hunt_audio_held", build(tbl[3].base, tbl[3].step));

        // Relock
        send_bit(1'b1, 1'b1);
        run_frame(build(24'h0F0000, 24'h000101), 8'hC3, 1'b1);

        // Early fsync at slot 5 bit 10
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_frame(build(24'hDEAD00, 24'h000011), 8'h00, 1'b0, 5 * 32 + 10);
        send_bit(1'b1, 1'b1);
        idle(4);
        check_val("early_error_pulse", err_cnt, e0 + 1);
        check_val("early_no_strobe", strobe_cnt, s0);
        check_val("early_locked", int'(locked), 0);
        check_audio("early_audio_held", build(24'h0F0000, 24'h000101));
        run_frame(build(24'h555555, 24'h000000), 8'h00, 1'b1);

        // Reset in the middle of slot 9
        send_frame(build(24'hBEEF00, 24'h000003), 8'h00, 1'b0, 9 * 32 + 12);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_audio("midreset_audio", '0);
        check_val("midreset_locked", int'(locked), 0);
        check_val("midreset_strobe", int'(frame_strobe), 0);
        reset_n = 1'b1;
        idle(4);
        send_bit(1'b1, 1'b0);
        run_frame(build(24'h3C0000, 24'h000007), 8'h0F, 1'b1);

        check_val("strobe_count", strobe_cnt, exp_frames);
        check_val("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
